// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and the legality check for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // An access is legal when funct3 names a supported width and the address
    // is naturally aligned for it; unsigned widths exist for loads only.
    function automatic logic is_legal(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    is_legal = 1'b1;
            F3_H:    is_legal = ~addr_lo[0];
            F3_W:    is_legal = (addr_lo == 2'b00);
            F3_BU:   is_legal = ~we;
            F3_HU:   is_legal = ~we & ~addr_lo[0];
            default: is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-wide data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables and data steering on the way
// out, lane extraction and sign/zero extension on the way back.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        st_we,
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_lane_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;

    // Stores replicate the narrow datum across the word and enable only its lanes.
    always_comb begin
        st_be         = 4'b1111;
        st_lane_wdata = st_wdata;
        if (!st_we) begin
            st_lane_wdata = '0;
        end else begin
            case (st_funct3)
                F3_B: begin
                    st_be         = 4'b0001 << st_addr_lo;
                    st_lane_wdata = {4{st_wdata[7:0]}};
                end
                F3_H: begin
                    st_be         = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                    st_lane_wdata = {2{st_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Loads pick the addressed lane, then extend according to signedness.
    always_comb begin
        case (ld_addr_lo)
            2'd0:    ld_byte = $signed(ld_rdata[7:0]);
            2'd1:    ld_byte = $signed(ld_rdata[15:8]);
            2'd2:    ld_byte = $signed(ld_rdata[23:16]);
            default: ld_byte = $signed(ld_rdata[31:24]);
        endcase
        ld_half = ld_addr_lo[1] ? $signed(ld_rdata[31:16]) : $signed(ld_rdata[15:0]);
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'b0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'b0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates the core's access, runs one bus transaction
// per legal access, and holds the core stalled until the access completes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_fault,
    output logic        lsu_err,
    lsu_if.master       bus
);

    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    lsu_state_t  state;
    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_addr_lo;
    logic [31:0] to_cnt;

    logic        legal;
    logic        timeout_hit;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign legal       = is_legal(lsu_we, lsu_funct3, lsu_addr[1:0]);
    // Fault and the request-cycle stall are combinational so the core reacts
    // in the same cycle it presents the access.
    assign lsu_fault   = (state == IDLE) & lsu_req & ~legal;
    assign lsu_stall   = ((state == IDLE) & lsu_req & legal) | (state == REQ);
    // The counter holds the number of completed REQ cycles minus one.
    assign timeout_hit = (TIMEOUT_LIM != 32'd0) && ((to_cnt + 32'd1) >= TIMEOUT_LIM);

    // Store lanes come from the live operands; load lanes from the latched ones.
    lsu_align u_align (
        .st_we         (lsu_we),
        .st_funct3     (lsu_funct3),
        .st_addr_lo    (lsu_addr[1:0]),
        .st_wdata      (lsu_wdata),
        .st_be         (st_be),
        .st_lane_wdata (st_wdata),
        .ld_funct3     (lat_funct3),
        .ld_addr_lo    (lat_addr_lo),
        .ld_rdata      (bus.bus_rdata),
        .ld_data       (ld_data)
    );

    // Access FSM with operand latches, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            lat_we        <= 1'b0;
            lat_funct3    <= 3'b000;
            lat_addr_lo   <= 2'b00;
            to_cnt        <= '0;
            lsu_rdata     <= '0;
            lsu_done      <= 1'b0;
            lsu_err       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= 4'b0000;
            bus.bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_req && legal) begin
                        lat_we        <= lsu_we;
                        lat_funct3    <= lsu_funct3;
                        lat_addr_lo   <= lsu_addr[1:0];
                        to_cnt        <= '0;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= lsu_we;
                        bus.bus_addr  <= {lsu_addr[31:2], 2'b00};
                        bus.bus_be    <= st_be;
                        bus.bus_wdata <= st_wdata;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        lsu_done    <= 1'b1;
                        lsu_rdata   <= lat_we ? 32'd0 : ld_data;
                        state       <= DONE;
                    end else if (timeout_hit) begin
                        bus.bus_req <= 1'b0;
                        lsu_done    <= 1'b1;
                        lsu_err     <= 1'b1;
                        lsu_rdata   <= '0;
                        state       <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                DONE: begin
                    lsu_done  <= 1'b0;
                    lsu_err   <= 1'b0;
                    lsu_rdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and randomized accesses, with per-cycle
// expectations derived from a transaction-level model of the access rules.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_req;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic        lsu_fault;
    logic        lsu_err;

    lsu_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .lsu_funct3 (lsu_funct3),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_rdata  (lsu_rdata),
        .lsu_stall  (lsu_stall),
        .lsu_done   (lsu_done),
        .lsu_fault  (lsu_fault),
        .lsu_err    (lsu_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Expected outputs for the current cycle, written by the driver.
    logic        e_stall, e_fault, e_done, e_err, e_busreq, e_we, e_wchk;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int unsigned lo;
        lo = a % 4;
        case (f3)
            3'd0:    return 1'b1;
            3'd1:    return (lo % 2) == 0;
            3'd2:    return lo == 0;
            3'd4:    return !we;
            3'd5:    return !we && ((lo % 2) == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int unsigned lo;
        lo = a % 4;
        if (!we) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << lo);
        if (f3 == 3'd1) return 4'(3 << lo);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_store(input logic [2:0] f3, input logic [31:0] w);
        if (f3 == 3'd0) return (w & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [2:0] f3, input logic [31:0] a);
        int unsigned lo;
        logic [31:0] v;
        lo = a % 4;
        case (f3)
            3'd0, 3'd4: begin
                v = (rd >> (8 * lo)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (rd >> (8 * (lo & 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'b0, lsu_stall}, {31'b0, e_stall});
            chk("fault", {31'b0, lsu_fault}, {31'b0, e_fault});
            chk("done", {31'b0, lsu_done}, {31'b0, e_done});
            chk("err", {31'b0, lsu_err}, {31'b0, e_err});
            chk("bus_req", {31'b0, bus.bus_req}, {31'b0, e_busreq});
            if (e_busreq) begin
                chk("bus_we", {31'b0, bus.bus_we}, {31'b0, e_we});
                chk("bus_addr", bus.bus_addr, e_addr);
                chk("bus_be", {28'b0, bus.bus_be}, {28'b0, e_be});
                if (e_wchk) chk("bus_wdata", bus.bus_wdata, e_wdata);
            end
            if (e_done) chk("rdata", lsu_rdata, e_rdata);
        end
    end

    // ---------------- driver ----------------
    task automatic set_idle_exp();
        e_stall = 1'b0; e_fault = 1'b0; e_done = 1'b0; e_err = 1'b0; e_busreq = 1'b0;
        e_we = 1'b0; e_wchk = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0; e_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        next_cycle();
        lsu_req   = 1'b0;
        bus_ack_r = 1'($urandom_range(0, 1));
        bus_rd_r  = $urandom;
        set_idle_exp();
    endtask

    logic        bus_ack_r;
    logic [31:0] bus_rd_r;
    assign bus.bus_ack   = bus_ack_r;
    assign bus.bus_rdata = bus_rd_r;

    // One access from the core. ack_at = REQ cycle carrying the ack (0 = never).
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at);
        int   k;
        logic fin;
        logic timed_out;
        next_cycle();
        lsu_req    = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = addr;
        lsu_wdata  = wdata;
        bus_ack_r  = 1'($urandom_range(0, 1));
        bus_rd_r   = $urandom;
        set_idle_exp();
        if (!m_legal(we, f3, addr)) begin
            e_fault = 1'b1;
            return;
        end
        e_stall = 1'b1;
        k   = 0;
        fin = 1'b0;
        while (!fin) begin
            next_cycle();
            k++;
            bus_ack_r = (k == ack_at);
            bus_rd_r  = (k == ack_at) ? rdata : $urandom;
            e_stall   = 1'b1;
            e_busreq  = 1'b1;
            e_we      = we;
            e_addr    = {addr[31:2], 2'b00};
            e_be      = m_be(we, f3, addr);
            e_wchk    = we;
            e_wdata   = m_store(f3, wdata);
            if (k == ack_at || k == TO) fin = 1'b1;
        end
        timed_out = (k != ack_at);
        next_cycle();
        bus_ack_r  = 1'($urandom_range(0, 1));
        bus_rd_r   = $urandom;
        lsu_req    = 1'($urandom_range(0, 1));
        lsu_we     = 1'($urandom_range(0, 1));
        lsu_funct3 = 3'($urandom_range(0, 7));
        lsu_addr   = $urandom;
        set_idle_exp();
        e_done  = 1'b1;
        e_err   = timed_out;
        e_rdata = (timed_out || we) ? 32'd0 : m_load(rdata, f3, addr);
    endtask

    task automatic reset_mid_req();
        next_cycle();
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'd2; lsu_addr = 32'h300; lsu_wdata = '0;
        bus_ack_r = 1'b0;
        set_idle_exp();
        e_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            bus_ack_r = 1'b0;
            if (i == 1) reset = 1'b1;
            e_stall = 1'b1; e_busreq = 1'b1; e_we = 1'b0; e_addr = 32'h300; e_be = 4'hF; e_wchk = 1'b0;
        end
        next_cycle();
        reset = 1'b0; lsu_req = 1'b0; bus_ack_r = 1'b1; bus_rd_r = 32'h12345678;
        set_idle_exp();
        next_cycle();
        bus_ack_r = 1'b1;
        set_idle_exp();
    endtask

    initial begin
        int r;
        reset = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = '0; lsu_addr = '0; lsu_wdata = '0;
        bus_ack_r = 1'b0; bus_rd_r = '0;
        set_idle_exp();

        // Literal pins on the model itself.
        chk("pin_lb",   m_load(32'h80FF7F01, 3'd0, 32'h103), 32'hFFFFFF80);
        chk("pin_lbu",  m_load(32'h80FF7F01, 3'd4, 32'h103), 32'h00000080);
        chk("pin_lh",   m_load(32'h80FF7F01, 3'd1, 32'h102), 32'hFFFF80FF);
        chk("pin_lhu",  m_load(32'h80FF7F01, 3'd5, 32'h100), 32'h00007F01);
        chk("pin_sb_w", m_store(3'd0, 32'h000000A5), 32'hA5A5A5A5);
        chk("pin_sb_be", {28'b0, m_be(1'b1, 3'd0, 32'h203)}, 32'h8);
        chk("pin_sh_be", {28'b0, m_be(1'b1, 3'd1, 32'h202)}, 32'hC);
        chk("pin_sh_w", m_store(3'd1, 32'h00001234), 32'h12341234);
        chk("pin_lw_mis", {31'b0, m_legal(1'b0, 3'd2, 32'h102)}, 32'h0);
        chk("pin_sh_mis", {31'b0, m_legal(1'b1, 3'd1, 32'h101)}, 32'h0);
        chk("pin_f3_011", {31'b0, m_legal(1'b0, 3'd3, 32'h100)}, 32'h0);
        chk("pin_sw_be", {28'b0, m_be(1'b1, 3'd2, 32'h104)}, 32'hF);

        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        reset = 1'b0;

        // Directed scenarios.
        do_access(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0, 1);
        do_access(1'b1, 3'd0, 32'h203, 32'h000000A5, 32'h0, 1);
        do_access(1'b1, 3'd1, 32'h202, 32'h00001234, 32'h0, 2);
        do_access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF7F01, 1);
        do_access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF7F01, 3);
        do_access(1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF7F01, 1);
        do_access(1'b0, 3'd5, 32'h100, 32'h0, 32'h80FF7F01, 2);
        do_access(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 1);
        do_access(1'b1, 3'd1, 32'h101, 32'h1234, 32'h0, 1);
        do_access(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1);
        idle_cycle();
        do_access(1'b0, 3'd2, 32'h400, 32'h0, 32'hCAFEF00D, 0);
        do_access(1'b0, 3'd2, 32'h404, 32'h0, 32'hCAFEF00D, TO);
        idle_cycle();
        reset_mid_req();
        idle_cycle();

        // Randomized accesses.
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 15));
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                      (r == 0) ? 0 : int'($urandom_range(1, 4)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        next_cycle();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
